// File: rtl/pwm_peripheral.sv
// Shared-phase PWM driver for 16 pins with prescaled 8-bit period counter.
// Duty is shadowed at the period wrap so mid-period writes never create runt pulses.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] en_out,
  input  logic [15:0] en_pwm,
  input  logic [7:0]  pwm_duty,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic [7:0]    duty_sh;
  logic          load_pend;
  logic          pwm_sig;
  logic          tick;
  logic          wrap;

  assign tick = (presc == PLAST);
  assign wrap = tick && (cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      cnt          <= '0;
      duty_sh      <= '0;
      load_pend    <= 1'b1;
      pwm_sig      <= 1'b0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      // Counters hold during the initial load so the first period is full length
      if (load_pend) begin
        duty_sh      <= pwm_duty;
        load_pend    <= 1'b0;
        period_start <= 1'b1;
      end else begin
        presc        <= tick ? '0 : presc + 1'b1;
        if (tick)
          cnt <= cnt + 8'd1;
        if (wrap)
          duty_sh <= pwm_duty;
        period_start <= wrap;
      end
      pwm_sig <= (duty_sh == 8'hFF) | (cnt < duty_sh);
      for (int i = 0; i < 16; i++)
        out[i] <= en_out[i] ? (en_pwm[i] ? pwm_sig : 1'b1) : 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: CLK_DIV=2 main instance, CLK_DIV=1 regression.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  pwm_duty;
  logic [15:0] out2, out1;
  logic        ps2, ps1;

  int vectors = 0;
  int errors  = 0;
  int hi[4];
  int upper_bad;
  int skew_bad;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(2)) u2 (
    .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm),
    .pwm_duty(pwm_duty), .out(out2), .period_start(ps2)
  );

  pwm_peripheral #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm),
    .pwm_duty(pwm_duty), .out(out1), .period_start(ps1)
  );

  task automatic wait_ps2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ps2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ps1(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (ps1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sync2(input string name);
    bit ok;
    wait_ps2(ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: period_start timeout, got none, need pulse", name);
    end
  endtask

  // Called at the negedge where ps2 is seen; out lags cnt by 2 clks.
  task automatic run_periods(input int n,
                             input int wk1, input logic [7:0] wv1,
                             input int wk2, input logic [7:0] wv2);
    for (int p = 0; p < 4; p++) hi[p] = 0;
    upper_bad = 0;
    skew_bad  = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 512 * n; k++) begin
      if (k == wk1) pwm_duty = wv1;
      if (k == wk2) pwm_duty = wv2;
      hi[k / 512] += int'(out2[0]);
      if (out2[15:8] !== 8'h00) upper_bad++;
      if (out2[7:0] !== {8{out2[0]}}) skew_bad++;
      @(negedge clk);
    end
  endtask

  task automatic chk_hi(input string name, input int p, input int exp);
    vectors++;
    if (hi[p] !== exp) begin
      errors++;
      $display("FAIL %s: period %0d high clks got %0d need %0d",
               name, p, hi[p], exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en_out = '0;
    en_pwm = '0;
    pwm_duty = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (out2 !== 16'h0 || ps2 !== 1'b0 || out1 !== 16'h0 || ps1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: out2=%h ps2=%b out1=%h ps1=%b need 0",
                 out2, ps2, out1, ps1);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ps2 !== 1'b1 || ps1 !== 1'b1) begin
      errors++;
      $display("FAIL first_ps: ps2=%b ps1=%b need 1", ps2, ps1);
    end
    @(negedge clk);
    vectors++;
    if (ps2 !== 1'b0) begin
      errors++;
      $display("FAIL ps_width: ps2=%b need 0", ps2);
    end
  endtask

  task automatic test_static;
    int bad;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    @(negedge clk);
    vectors++;
    if (out2 !== 16'hFFFF || out1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL static_lat: out2=%h out1=%h need ffff", out2, out1);
    end
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (out2 !== 16'hFFFF) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL static_hold: %0d bad clks need 0", bad);
    end
  endtask

  task automatic test_pwm_half;
    en_out = 16'h00FF;
    en_pwm = 16'h00FF;
    pwm_duty = 8'h80;
    sync2("half_sync");
    run_periods(3, -1, 8'h0, -1, 8'h0);
    for (int p = 0; p < 3; p++) chk_hi("half", p, 256);
    vectors++;
    if (upper_bad != 0 || skew_bad != 0) begin
      errors++;
      $display("FAIL half_pins: upper=%0d skew=%0d need 0 0",
               upper_bad, skew_bad);
    end
  endtask

  task automatic test_boundaries;
    pwm_duty = 8'h00;
    sync2("d00_sync");
    run_periods(2, -1, 8'h0, -1, 8'h0);
    chk_hi("d00", 0, 0);
    chk_hi("d00", 1, 0);
    pwm_duty = 8'hFF;
    sync2("dff_sync");
    run_periods(2, -1, 8'h0, -1, 8'h0);
    chk_hi("dff", 0, 512);
    chk_hi("dff", 1, 512);
    pwm_duty = 8'h01;
    sync2("d01_sync");
    run_periods(2, -1, 8'h0, -1, 8'h0);
    chk_hi("d01", 0, 2);
    chk_hi("d01", 1, 2);
  endtask

  task automatic test_duty_update;
    pwm_duty = 8'h40;
    sync2("upd_sync");
    // k=100 is mid-period; k=512+509 lands on the wrap cycle
    run_periods(3, 100, 8'hC0, 512 + 509, 8'h20);
    chk_hi("upd_cur", 0, 128);
    chk_hi("upd_next", 1, 384);
    chk_hi("upd_wrap", 2, 64);
  endtask

  task automatic test_reset_mid;
    int n, h;
    bit ok;
    pwm_duty = 8'h80;
    sync2("rmid_sync");
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (out2 !== 16'h0 || ps2 !== 1'b0 || out1 !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: out2=%h ps2=%b out1=%h need 0", out2, ps2, out1);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ps2 !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_ps: ps2=%b need 1", ps2);
    end
    run_periods(1, -1, 8'h0, -1, 8'h0);
    chk_hi("rst_restart", 0, 256);
    wait_ps1(n, ok);
    for (int r = 0; r < 2; r++) begin
      wait_ps1(n, ok);
      vectors++;
      if (!ok || n != 256) begin
        errors++;
        $display("FAIL div1_spacing: got %0d ok=%0b need 256", n, ok);
      end
    end
    repeat (2) @(negedge clk);
    h = 0;
    for (int k = 0; k < 256; k++) begin
      h += int'(out1[0]);
      @(negedge clk);
    end
    vectors++;
    if (h != 128) begin
      errors++;
      $display("FAIL div1_high: got %0d need 128", h);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_pwm_half();
    test_boundaries();
    test_duty_update();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
